// File: rtl/tft_arbiter_if.sv
// rtl/tft_arbiter_if.sv - TFT byte bus between the arbiter and the TFT serial driver
interface tft_arbiter_if;
  logic       tft_busy;
  logic       tft_transmit;
  logic       tft_dc;
  logic [7:0] tft_data;

  // Arbiter side: drives the byte, listens to driver busy
  modport master (
    input  tft_busy,
    output tft_transmit,
    output tft_dc,
    output tft_data
  );

  // TFT driver side
  modport slave (
    output tft_busy,
    input  tft_transmit,
    input  tft_dc,
    input  tft_data
  );
endinterface

// File: rtl/tft_arbiter.sv
// rtl/tft_arbiter.sv - round-robin TFT byte-bus arbiter; TFT_ARBITER_PRIORITY_EN selects fixed priority
module tft_arbiter #(
  parameter int clients   = 4,
  parameter int busy_wait = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [clients-1:0]     req,
  output logic [clients-1:0]     client_enable,
  output logic [clients-1:0]     client_draw,
  input  logic [clients-1:0]     client_busy,
  input  logic [clients-1:0]     client_transmit,
  input  logic [clients-1:0]     client_dc,
  input  logic [8*clients-1:0]   client_data,
  output logic [clients-1:0]     client_tft_busy,
  output logic [clients-1:0]     ack,
  output logic                   idle,
  tft_arbiter_if.master          tft
);

  localparam int GW = (clients > 1) ? $clog2(clients) : 1;
  localparam int CW = $clog2(busy_wait + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [clients-1:0] pending_q, pending_d;
  logic [GW-1:0]      rr_q, rr_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [clients-1:0] enable_q, enable_d;
  logic [clients-1:0] draw_q, draw_d;
  logic [clients-1:0] ack_q, ack_d;
  logic               xmit_q, xmit_d;
  logic               dc_q, dc_d;
  logic [7:0]         data_q, data_d;
  logic               idle_q, idle_d;

  logic [GW-1:0]      sel;
  logic               sel_valid;
  logic [GW:0]        sel_sum;
  logic [GW-1:0]      sel_idx;

  logic               cur_busy;
  logic               cur_transmit;
  logic               cur_dc;
  logic [7:0]         cur_data;
  logic               cur_enable;

  function automatic logic [clients-1:0] onehot(input logic [GW-1:0] g);
    logic [clients-1:0] oh;
    for (int i = 0; i < clients; i++) begin
      oh[i] = (g == GW'(i));
    end
    return oh;
  endfunction

  // Pick the next client: first pending index at or after rr (or lowest index in priority mode)
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    sel_sum   = '0;
    sel_idx   = '0;
    for (int k = 0; k < clients; k++) begin
`ifdef TFT_ARBITER_PRIORITY_EN
      sel_sum = (GW+1)'(k);
`else
      sel_sum = {1'b0, rr_q} + (GW+1)'(k);
      if (sel_sum >= (GW+1)'(clients)) begin
        sel_sum = sel_sum - (GW+1)'(clients);
      end
`endif
      sel_idx = sel_sum[GW-1:0];
      if (!sel_valid && pending_q[sel_idx]) begin
        sel       = sel_idx;
        sel_valid = 1'b1;
      end
    end
  end

  // Route the granted client's signals out of the per-client vectors
  always_comb begin
    cur_busy     = 1'b0;
    cur_transmit = 1'b0;
    cur_dc       = 1'b0;
    cur_data     = 8'h00;
    cur_enable   = 1'b0;
    for (int i = 0; i < clients; i++) begin
      if (grant_q == GW'(i)) begin
        cur_busy     = client_busy[i];
        cur_transmit = client_transmit[i];
        cur_dc       = client_dc[i];
        cur_data     = client_data[i*8 +: 8];
        cur_enable   = enable_q[i];
      end
    end
  end

  // Grant FSM next state, request latching and registered-output next values
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | req;
    rr_d      = rr_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    ack_d     = '0;

    case (state_q)
      S_IDLE: begin
        if (sel_valid) begin
          grant_d   = sel;
          rr_d      = (sel == GW'(clients - 1)) ? '0 : sel + 1'b1;
          // A req arriving in the grant cycle re-queues the same client
          pending_d = (pending_q & ~onehot(sel)) | req;
          state_d   = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cur_busy) begin
          state_d = S_RUN;
        end else begin
          if (cnt_q != CW'(busy_wait)) begin
            cnt_d = cnt_q + 1'b1;
          end
          // Client never acknowledged the draw strobe: abandon the grant
          if (cnt_d == CW'(busy_wait)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_RUN: begin
        if (!cur_busy) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Hold until the last forwarded byte has been taken by the driver
        if (!tft.tft_busy && !xmit_q) begin
          ack_d   = onehot(grant_q);
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    enable_d = (state_d inside {S_START, S_WAIT, S_RUN}) ? onehot(grant_d) : '0;
    draw_d   = (state_d == S_START) ? onehot(grant_d) : '0;
    xmit_d   = ((state_q == S_WAIT) || (state_q == S_RUN)) && cur_transmit && cur_enable;
    dc_d     = cur_dc;
    data_d   = cur_data;
    idle_d   = (state_d == S_IDLE) && (pending_d == '0);
  end

  // State and registered outputs; reset drops any grant in flight without an ack
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      rr_q      <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
      enable_q  <= '0;
      draw_q    <= '0;
      ack_q     <= '0;
      xmit_q    <= 1'b0;
      dc_q      <= 1'b0;
      data_q    <= 8'h00;
      idle_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      enable_q  <= enable_d;
      draw_q    <= draw_d;
      ack_q     <= ack_d;
      xmit_q    <= xmit_d;
      dc_q      <= dc_d;
      data_q    <= data_d;
      idle_q    <= idle_d;
    end
  end

  // Granted client sees driver busy widened by the byte still in the output register
  always_comb begin
    for (int i = 0; i < clients; i++) begin
      client_tft_busy[i] = enable_q[i] ? (tft.tft_busy | xmit_q) : 1'b1;
    end
  end

  assign client_enable    = enable_q;
  assign client_draw      = draw_q;
  assign ack              = ack_q;
  assign idle             = idle_q;
  assign tft.tft_transmit = xmit_q;
  assign tft.tft_dc       = dc_q;
  assign tft.tft_data     = data_q;

endmodule

// File: doc/tft_arbiter.md
Name: tft_arbiter

Overview:
- Shares the single TFT byte interface (tft_busy/tft_dc/tft_data/tft_transmit) between N drawing clients such as the player sprite, maze tiles and the score overlay.
- Latches draw requests and grants one client at a time, round-robin.
- Issues the client's enable and draw strobe, then multiplexes that client's byte stream onto the TFT bus until the client's busy drops.
- Sits between the drawing clients and the TFT serial driver; the only block that drives the TFT byte inputs.

Parameters:
- clients, 4, number of requesting drawing clients (2..8).
- busy_wait, 4, cycles after a draw strobe within which client_busy must rise, else the grant is abandoned.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- req  input  clients  per-client draw request, single-cycle pulse or level; latched into pending.
- client_enable  output  clients  enable to each client; high only for the granted client.
- client_draw  output  clients  one-cycle draw strobe to the granted client.
- client_busy  input  clients  busy output of each client.
- client_transmit  input  clients  per-client byte strobe.
- client_dc  input  clients  per-client data/command flag.
- client_data  input  8*clients  per-client byte; client i occupies bits [8i+7:8i].
- client_tft_busy  output  clients  tft_busy as seen by each client.
- tft_busy  input  1  TFT driver busy.
- tft_transmit  output  1  registered byte strobe to the TFT driver.
- tft_dc  output  1  registered data/command flag.
- tft_data  output  8  registered byte.
- ack  output  clients  one-cycle done pulse for the client whose grant ended.
- idle  output  1  high in IDLE with no pending requests.

Behaviour:
- Reset (sync, active high):
  - Outputs: client_enable=0, client_draw=0, ack=0, tft_transmit=0, tft_dc=0, tft_data=0, idle=1.
  - Internal: pending=0, rr pointer=0, grant index=0, state IDLE.
  - Reset mid-transfer abandons the grant without an ack.
- Request latching:
  - pending[i] is set on any cycle with req[i]=1.
  - pending[i] is cleared in the cycle client i is granted; a req[i] in that same cycle keeps it set, queueing one further draw.
- Grant selection:
  - Round-robin: the first pending index at or after rr, wrapping modulo clients.
  - rr becomes the granted index + 1, wrapping from clients-1 to 0.
- FSM states:
  - IDLE: if any pending bit is set, select a grant, go to START.
  - START: client_enable[g]=1, client_draw[g]=1 for exactly this cycle, clear the wait counter, go to WAIT.
  - WAIT: client_enable[g]=1. When client_busy[g]=1, go to RUN. If the counter reaches busy_wait first, go to DRAIN (abandoned grant).
  - RUN: client_enable[g]=1. When client_busy[g]=0, go to DRAIN.
  - DRAIN: client_enable[g]=0. Stay until tft_busy=0 and tft_transmit=0, then pulse ack[g] for one cycle and go to IDLE.
  - An abandoned grant still acks.
  - IDLE evaluates requests in the same cycle as that ack, so back-to-back grants have one idle cycle.
- Byte path:
  - Each cycle: tft_transmit <= client_transmit[g] & client_enable[g]; tft_dc <= client_dc[g]; tft_data <= client_data[g].
  - Latency is exactly 1 cycle; outside WAIT/RUN, tft_transmit is 0.
- Busy forwarding:
  - client_tft_busy[g] = tft_busy | tft_transmit. This covers the one-cycle pipeline gap so a client never issues two bytes before the driver reports busy.
  - Non-granted clients see client_tft_busy=1.
- Width rules:
  - Grant index is $clog2(clients) bits.
  - Wait counter is $clog2(busy_wait+1) bits and saturates.
- Simultaneous events:
  - client_busy falling in the same cycle as a transmit: the byte is forwarded and DRAIN waits for it.
  - All clients pending: served in index order starting at rr.

Optional Feature:
- Macro: TFT_ARBITER_PRIORITY_EN.
- Defined: fixed priority; the lowest pending index always wins and rr is ignored (player is wired to index 0).
- Undefined: round-robin as above.

Test Plan:
- Single request:
  - Stimulus: req=4'b0010 pulse; client 1 model raises busy 2 cycles after its draw strobe, sends bytes 8'h2a (dc=0), 8'h00 (dc=1), then drops busy.
  - Required: client_draw=4'b0010 for 1 cycle; tft_data sequence 2a,00 each 1 cycle after the client strobe; exactly one ack[1] pulse; idle=1 afterwards.
- Round-robin:
  - Stimulus: req=4'b1011 in one cycle, rr=0.
  - Required: grant order 0,1,3; repeat req=4'b1011 gives order 0,1,3 again.
  - With TFT_ARBITER_PRIORITY_EN and req[0] re-asserted during each grant: 0 is served every time.
- Busy timeout:
  - Stimulus: client 2 never raises busy.
  - Required: after busy_wait=4 WAIT cycles, DRAIN then ack[2]; tft_transmit never asserted.
- Isolation:
  - Stimulus: client 3 toggles transmit while client 0 is granted.
  - Required: no tft_transmit from client 3; client_tft_busy[3]=1 throughout.
- Back-pressure:
  - Stimulus: hold tft_busy=1 for 10 cycles after the granted client's last byte while busy falls.
  - Required: ack asserts only after tft_busy=0.
- Reset mid-RUN:
  - Stimulus: assert rst.
  - Required: next cycle all outputs at reset values, pending=0, no ack.
